// File: rtl/esc_pkg.sv
// ============================================================================
// Module      : esc_pkg
// Description : Shared constants and types for the ESC ADC receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package esc_pkg;

    localparam int ADC_NUM_LANES = 5;
    localparam int ADC_WORD_BITS = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } adc_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_bits.sv
// ============================================================================
// Module      : sync_bits
// Description : Vector of independent 2-FF synchronizers, reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_bits #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

`default_nettype wire

// File: rtl/adc_frame_rx.sv
// ============================================================================
// Module      : adc_frame_rx
// Description : Oversampling multi-lane ADC frame receiver (MSB-first words).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frame_rx
    import esc_pkg::*;
#(
    parameter int NUM_LANES   = ADC_NUM_LANES,
    parameter int WORD_BITS   = ADC_WORD_BITS,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                           clk_ctrl,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           dclk,
    input  logic                           drdy,
    input  logic [NUM_LANES-1:0]           adc_d,
    output logic [NUM_LANES*WORD_BITS-1:0] sample_data,
    output logic                           sample_valid,
    output logic                           frame_err,
    output logic [15:0]                    frame_cnt,
    output logic                           busy
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    logic [NUM_LANES+1:0]           sync_q;
    logic                           dclk_d;
    logic                           bit_ev;
    logic                           ev_drdy;
    logic                           drdy_last;
    logic [NUM_LANES-1:0]           ev_lanes;
    logic                           frame_start;
    logic [NUM_LANES*WORD_BITS-1:0] shreg_all;

    adc_rx_state_t    state, state_nx;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;
    logic [15:0]      frame_cnt_q;
    logic             load, shift_en, capture, valid_nx, err_nx;

    // One synchronizer bank for clock, ready and lanes keeps them cycle-aligned.
    sync_bits #(
        .WIDTH(NUM_LANES + 2)
    ) u_sync (
        .clk  (clk_ctrl),
        .rst_n(rst_n),
        .d    ({dclk, drdy, adc_d}),
        .q    (sync_q)
    );

    // Edge stage: lane and drdy bits are delayed with the event so they stay aligned.
    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            dclk_d    <= 1'b0;
            bit_ev    <= 1'b0;
            ev_drdy   <= 1'b0;
            ev_lanes  <= '0;
            drdy_last <= 1'b0;
        end else begin
            dclk_d   <= sync_q[NUM_LANES+1];
            bit_ev   <= sync_q[NUM_LANES+1] & ~dclk_d;
            ev_drdy  <= sync_q[NUM_LANES];
            ev_lanes <= sync_q[NUM_LANES-1:0];
            if (bit_ev) drdy_last <= ev_drdy;
        end
    end

    assign frame_start = bit_ev & ev_drdy & ~drdy_last;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [WORD_BITS-1:0] shreg;
        always_ff @(posedge clk_ctrl or negedge rst_n) begin
            if (!rst_n)        shreg <= '0;
            else if (load)     shreg <= {{(WORD_BITS-1){1'b0}}, ev_lanes[k]};
            else if (shift_en) shreg <= {shreg[WORD_BITS-2:0], ev_lanes[k]};
        end
        assign shreg_all[k*WORD_BITS +: WORD_BITS] = shreg;
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        to_cnt_nx  = to_cnt;
        load       = 1'b0;
        shift_en   = 1'b0;
        capture    = 1'b0;
        valid_nx   = 1'b0;
        err_nx     = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state_nx   = SHIFT;
                        load       = 1'b1;
                        bit_cnt_nx = CNT_W'(1);
                        to_cnt_nx  = '0;
                    end
                end
                SHIFT: begin
                    if (frame_start) begin
                        // Premature drdy: drop the partial word, restart on this event.
                        err_nx     = 1'b1;
                        load       = 1'b1;
                        bit_cnt_nx = CNT_W'(1);
                        to_cnt_nx  = '0;
                    end else if (bit_ev) begin
                        shift_en   = 1'b1;
                        bit_cnt_nx = bit_cnt + CNT_W'(1);
                        to_cnt_nx  = '0;
                        if (bit_cnt == CNT_LAST) state_nx = DONE;
                    end else begin
                        to_cnt_nx = to_cnt + TO_W'(1);
                        if (to_cnt == TO_LAST) begin
                            state_nx = IDLE;
                            err_nx   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                    capture  = 1'b1;
                    valid_nx = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            sample_data  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state        <= state_nx;
            bit_cnt      <= bit_cnt_nx;
            to_cnt       <= to_cnt_nx;
            sample_valid <= valid_nx;
            frame_err    <= err_nx;
            if (capture) begin
                sample_data <= shreg_all;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign busy      = (state == SHIFT);

endmodule

`default_nettype wire

// File: doc/adc_frame_rx.md
# adc_frame_rx

Receives data frames from the external multi-lane sigma-delta ADC, which acts as the transmitter. Oversamples `dclk`, `drdy` and the five data lanes in the `clk_ctrl` domain, then shifts one MSB-first word per lane. Presents a parallel sample vector with a one-cycle valid strobe to the timing hub and the current-loop logic. Sits between the ADC pins and all consumers of phase-current and voltage samples.

## Interface

Parameters:

- `NUM_LANES`, 5: number of ADC data lanes (`adc_d[NUM_LANES-1:0]`).
- `WORD_BITS`, 24: bits per lane per frame.
- `TIMEOUT_CYC`, 64: `clk_ctrl` cycles without a `dclk` rising edge, while shifting, that abort the frame.

Ports:

- `clk_ctrl`, in, 1: sole clock for the block. Frequency must be ≥ 4× `dclk`.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `en`, in, 1: receiver enable. While low, the block is forced to IDLE.
- `dclk`, in, 1: ADC data clock, asynchronous to `clk_ctrl`.
- `drdy`, in, 1: ADC data-ready, active-high, asynchronous.
- `adc_d`, in, NUM_LANES: data lanes, asynchronous. Launched on falling `dclk`, sampled on rising `dclk`.
- `sample_data`, out, NUM_LANES*WORD_BITS: last complete frame. Lane k occupies bits [k*WORD_BITS +: WORD_BITS]. Raw two's complement.
- `sample_valid`, out, 1: one-cycle strobe when `sample_data` updates.
- `frame_err`, out, 1: one-cycle strobe when a frame is aborted.
- `frame_cnt`, out, 16: count of good frames, wraps modulo 2^16.
- `busy`, out, 1: high while in SHIFT.

## Operation

- Input capture: `dclk`, `drdy` and all `adc_d` bits pass through identical 2-FF synchronizers, so lane/clock alignment is preserved. A third register on `dclk` and `drdy` provides edge detection.
- Bit event: synchronized `dclk` rising (0→1). All state changes occur only on bit events, except for timeout and `en`.
- Frame start: a bit event where synced `drdy` is 1 and `drdy` was 0 at the previous bit event. The lane bits at this event are the MSBs.
- States:
  - IDLE → SHIFT on frame start (when `en`=1). Load MSBs and set bit counter to 1.
  - SHIFT: on each bit event, shift in lane bits and increment the counter.
  - On the bit event that makes counter = WORD_BITS: go to DONE.
  - SHIFT → IDLE with `frame_err` on timeout.
  - DONE: for one cycle, copy the shift registers to `sample_data`, pulse `sample_valid`, increment `frame_cnt`, then go to IDLE.
- A frame start during SHIFT (premature `drdy`) pulses `frame_err`, discards the partial word, and restarts SHIFT with that event's bits as MSBs. `frame_cnt` is unchanged.
- Timeout counter: cleared on every bit event and on entry to SHIFT. Counts only in SHIFT. Reaching TIMEOUT_CYC aborts the frame.
- `en` deasserted in any state: go to IDLE next cycle. No `frame_err`, no `sample_valid`. `sample_data` and `frame_cnt` are retained.
- No backpressure. `sample_data` holds until the next DONE, and consumers must latch on `sample_valid`.
- `frame_err` and `sample_valid` never assert in the same cycle.

## Timing

- Reset values:
  - `sample_data` = 0, `sample_valid` = 0, `frame_err` = 0, `frame_cnt` = 0, `busy` = 0.
  - State = IDLE; synchronizers = 0.
- Latency: `sample_valid` asserts 4 `clk_ctrl` cycles after the first `clk_ctrl` edge that samples the final `dclk` rise high at the pin. The breakdown is 2 sync + 1 edge register + DONE.
- `busy` rises the cycle after the frame-start bit event. It falls on DONE exit, abort, or `en` low.
- Reset mid-frame: all state clears immediately. The first frame start after reset release is honored.
- Counter width is clog2(WORD_BITS+1); `frame_cnt` wraps 0xFFFF → 0x0000 without error.

## Structure

- Shared package `esc_pkg`:
  - `ADC_NUM_LANES` = 5 and `ADC_WORD_BITS` = 24.
  - `adc_rx_state_t` enum {IDLE, SHIFT, DONE}.
- Sub-module `sync_bits` (parameter WIDTH): a vector of 2-FF synchronizers with ASYNC_REG, instantiated once for {`dclk`, `drdy`, `adc_d`}.

## Test plan

- Single frame, `dclk` = clk/8, lane k = 0xA50000+k: exactly one `sample_valid`; each lane reads back its value; `frame_cnt` = 1; `busy` is low afterward.
- 300 back-to-back frames: 300 `sample_valid` pulses and 0 `frame_err`. Then preload 65534 frames (via force) plus 3 more: `frame_cnt` wraps to 0x0001.
- `drdy` re-asserted after 10 bits: one `frame_err`, no `sample_valid`. The following 24 bits are captured correctly as a new frame.
- `dclk` stopped after 12 bits for 64 cycles: `frame_err` pulses once, state returns to IDLE, and `sample_data` is unchanged.
- `en` dropped mid-frame, then `rst_n` pulsed low mid-frame: no strobes from either. After reset, all outputs are 0, and the next full frame is received correctly.
